// File: rtl/jogo_pkg.sv
// Shared definitions for the reaction-duel game: referee state set, match length
// default and the LFSR constants also used by the scoring block.
package jogo_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ARMED  = 3'd1,
      GO     = 3'd2,
      RESULT = 3'd3,
      DONE   = 3'd4
   } estado_t;

   localparam int unsigned WIN_LIMIT_DEF = 8;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Galois form of x^16 + x^14 + x^13 + x^11 + 1
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/sincroniza_borda.sv
// Brings one raw push-button into the clock domain and emits a one-cycle pulse
// on its rising edge, three clocks after the pin rises.
module sincroniza_borda (
   input  logic clk_i,
   input  logic rst_i,
   input  logic pino_i,
   output logic borda_o
);

   // [0],[1] synchronizer stages, [2] previous synchronized level
   logic [2:0] sinc_q;
   logic       borda_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sinc_q  <= 3'b000;
         borda_q <= 1'b0;
      end else begin
         sinc_q  <= {sinc_q[1:0], pino_i};
         borda_q <= sinc_q[1] & ~sinc_q[2];
      end
   end

   assign borda_o = borda_q;

endmodule

// File: rtl/arbitro_rodada.sv
// Reaction-duel round referee: arms a round, lights go_led after a random delay,
// awards the first button edge and emits p1vic/p2vic pulses to the scoring block.
// Optional macro FALSE_START_PENALTY_EN: a press while ARMED ends the round as a false start.
module arbitro_rodada
   import jogo_pkg::*;
#(
   parameter logic [31:0] DELAY_BASE = 32'd50_000_000,
   parameter logic [31:0] DELAY_MASK = 32'h3FF_FFFF,
   parameter logic [31:0] TIMEOUT    = 32'd100_000_000,
   parameter logic [31:0] COOLDOWN   = 32'd25_000_000,
   parameter int unsigned WIN_LIMIT  = WIN_LIMIT_DEF
) (
   input  logic clock,
   input  logic reset,
   input  logic start,
   input  logic btn_p1,
   input  logic btn_p2,
   output logic p1vic,
   output logic p2vic,
   output logic go_led,
   output logic round_active,
   output logic falta,
   output logic match_over
);

   localparam int WW = $clog2(WIN_LIMIT + 1);
   localparam logic [WW-1:0] WL = WW'(WIN_LIMIT);

   estado_t       est_q, est_d;
   logic [31:0]   cnt_q, cnt_d;
   logic [15:0]   lfsr_q;
   logic [WW-1:0] vit1_q, vit1_d, vit2_q, vit2_d;
   logic          p1vic_q, p1vic_d, p2vic_q, p2vic_d;
   logic          borda1, borda2;
   logic [31:0]   atraso;
   logic          fim_jogo;
`ifdef FALSE_START_PENALTY_EN
   logic          falta_q, falta_d;
`endif

   sincroniza_borda u_sinc_p1 (
      .clk_i   (clock),
      .rst_i   (reset),
      .pino_i  (btn_p1),
      .borda_o (borda1)
   );

   sincroniza_borda u_sinc_p2 (
      .clk_i   (clock),
      .rst_i   (reset),
      .pino_i  (btn_p2),
      .borda_o (borda2)
   );

   assign atraso   = DELAY_BASE + ({16'b0, lfsr_q} & DELAY_MASK);
   assign fim_jogo = (vit1_q == WL) || (vit2_q == WL);

   always_comb begin
      est_d   = est_q;
      cnt_d   = cnt_q;
      vit1_d  = vit1_q;
      vit2_d  = vit2_q;
      p1vic_d = 1'b0;
      p2vic_d = 1'b0;
`ifdef FALSE_START_PENALTY_EN
      falta_d = falta_q;
`endif
      case (est_q)
         IDLE: begin
            if (start) begin
               est_d = ARMED;
               cnt_d = atraso;
            end
         end
         ARMED: begin
`ifdef FALSE_START_PENALTY_EN
            // False start: the player who did not jump the gun takes the point
            if (borda1 || borda2) begin
               est_d   = RESULT;
               cnt_d   = COOLDOWN - 32'd1;
               falta_d = 1'b1;
               p1vic_d = borda2 & ~borda1;
               p2vic_d = borda1 & ~borda2;
            end else
`endif
            if (cnt_q == 32'd0) begin
               est_d = GO;
               cnt_d = TIMEOUT - 32'd1;
            end else begin
               cnt_d = cnt_q - 32'd1;
            end
         end
         GO: begin
            if (borda1 || borda2 || cnt_q == 32'd0) begin
               est_d   = RESULT;
               cnt_d   = COOLDOWN - 32'd1;
               p1vic_d = borda1 & ~borda2;
               p2vic_d = borda2 & ~borda1;
            end else begin
               cnt_d = cnt_q - 32'd1;
            end
         end
         RESULT: begin
            if (cnt_q == 32'd0) begin
`ifdef FALSE_START_PENALTY_EN
               falta_d = 1'b0;
`endif
               if (fim_jogo) begin
                  est_d = DONE;
               end else begin
                  est_d = ARMED;
                  cnt_d = atraso;
               end
            end else begin
               cnt_d = cnt_q - 32'd1;
            end
         end
         DONE: begin
            est_d = DONE;
         end
         default: begin
            est_d = IDLE;
         end
      endcase
      if (p1vic_d) vit1_d = vit1_q + WW'(1);
      if (p2vic_d) vit2_d = vit2_q + WW'(1);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         est_q   <= IDLE;
         cnt_q   <= 32'd0;
         lfsr_q  <= LFSR_SEED;
         vit1_q  <= '0;
         vit2_q  <= '0;
         p1vic_q <= 1'b0;
         p2vic_q <= 1'b0;
`ifdef FALSE_START_PENALTY_EN
         falta_q <= 1'b0;
`endif
      end else begin
         est_q   <= est_d;
         cnt_q   <= cnt_d;
         lfsr_q  <= lfsr_step(lfsr_q);
         vit1_q  <= vit1_d;
         vit2_q  <= vit2_d;
         p1vic_q <= p1vic_d;
         p2vic_q <= p2vic_d;
`ifdef FALSE_START_PENALTY_EN
         falta_q <= falta_d;
`endif
      end
   end

   assign p1vic        = p1vic_q;
   assign p2vic        = p2vic_q;
   assign go_led       = (est_q == GO);
   assign round_active = (est_q == ARMED) || (est_q == GO);
   assign match_over   = (est_q == DONE);
`ifdef FALSE_START_PENALTY_EN
   assign falta        = falta_q && (est_q == RESULT);
`else
   assign falta        = 1'b0;
`endif

endmodule

// File: tb/tb_arbitro_rodada.sv
// Bench for arbitro_rodada: table of scripted rounds, randomized rounds against a
// round-level scoring model, and hand sequences for match end, false start and reset.
`timescale 1ns/1ps
module tb_arbitro_rodada;

   localparam int DB = 20;
   localparam int DM = 7;
   localparam int TO = 50;
   localparam int CD = 10;
   localparam int WL = 8;

   localparam int A_P1  = 0;
   localparam int A_P2  = 1;
   localparam int A_TIE = 2;
   localparam int A_TO  = 3;

   logic clock = 1'b0;
   logic reset, start, btn_p1, btn_p2;
   logic p1vic, p2vic, go_led, round_active, falta, match_over;

   arbitro_rodada #(
      .DELAY_BASE (DB),
      .DELAY_MASK (DM),
      .TIMEOUT    (TO),
      .COOLDOWN   (CD),
      .WIN_LIMIT  (WL)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .btn_p1       (btn_p1),
      .btn_p2       (btn_p2),
      .p1vic        (p1vic),
      .p2vic        (p2vic),
      .go_led       (go_led),
      .round_active (round_active),
      .falta        (falta),
      .match_over   (match_over)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;
   int n_p1 = 0, n_p2 = 0, n_both = 0, n_falta = 0;

   always @(negedge clock) begin
      if (p1vic) n_p1++;
      if (p2vic) n_p2++;
      if (p1vic && p2vic) n_both++;
      if (falta) n_falta++;
   end

   typedef struct {
      int acao;
      int pd;
      int e1;
      int e2;
   } vec_t;

   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic check_rng(input string nm, input int act, input int lo, input int hi);
      total++;
      if (act < lo || act > hi) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; start = 1'b0; btn_p1 = 1'b0; btn_p2 = 1'b0;
      tick(); tick(); tick();
      check("reset p1vic", p1vic, 0);
      check("reset p2vic", p2vic, 0);
      check("reset go_led", go_led, 0);
      check("reset round_active", round_active, 0);
      check("reset falta", falta, 0);
      check("reset match_over", match_over, 0);
      reset = 1'b0;
      tick();
   endtask

   task automatic start_match();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start arms round", round_active, 1);
   endtask

   // One round from ARMED to the re-arm (or match end); returns pulse counts seen.
   task automatic play_round(input int acao, input int pd, output int d1, output int d2);
      int c, glen, rlen, b1, b2, f0;
      b1 = n_p1; b2 = n_p2; f0 = n_falta;
      c = 0;
      while (!go_led && c < 200) begin tick(); c++; end
      check("go_led reached", go_led, 1);
      check_rng("armed wait", c, DB, DB + DM + 3);
      glen = 0;
      for (int k = 0; k < pd; k++) begin tick(); glen++; end
      if (acao == A_P1 || acao == A_TIE) btn_p1 = 1'b1;
      if (acao == A_P2 || acao == A_TIE) btn_p2 = 1'b1;
      while (go_led && glen < TO + 20) begin tick(); glen++; end
      check("go_led dropped", go_led, 0);
      if (acao == A_TO) check_rng("go duration", glen, TO, TO + 1);
      btn_p1 = 1'b0; btn_p2 = 1'b0;
      rlen = 0;
      while (!round_active && !match_over && rlen < CD + 20) begin tick(); rlen++; end
      check("left result", round_active | match_over, 1);
      check_rng("result duration", rlen, CD, CD + 1);
      check("falta in go round", n_falta - f0, 0);
      d1 = n_p1 - b1;
      d2 = n_p2 - b2;
   endtask

   initial begin
      vec_t tab[6];
      int d1, d2, w1, w2, a, b1, b2, g, f0;

      tab[0] = '{A_P1,  2, 1, 0};
      tab[1] = '{A_TIE, 3, 0, 0};
      tab[2] = '{A_TO,  0, 0, 0};
      tab[3] = '{A_P2,  0, 0, 1};
      tab[4] = '{A_P1,  9, 1, 0};
      tab[5] = '{A_TIE, 0, 0, 0};

      // Scripted rounds
      do_reset();
      start_match();
      for (int i = 0; i < 6; i++) begin
         play_round(tab[i].acao, tab[i].pd, d1, d2);
         check($sformatf("tab%0d p1vic", i), d1, tab[i].e1);
         check($sformatf("tab%0d p2vic", i), d2, tab[i].e2);
         check($sformatf("tab%0d match_over", i), match_over, 0);
      end

      // Randomized rounds against a score model
      do_reset();
      start_match();
      w1 = 0; w2 = 0;
      for (int r = 0; r < 40 && w1 < WL && w2 < WL; r++) begin
         a = $urandom_range(0, 3);
         play_round(a, $urandom_range(0, 8), d1, d2);
         if (a == A_P1) w1++;
         if (a == A_P2) w2++;
         check("rand p1vic", d1, (a == A_P1) ? 1 : 0);
         check("rand p2vic", d2, (a == A_P2) ? 1 : 0);
         check("rand match_over", match_over, (w1 >= WL || w2 >= WL) ? 1 : 0);
      end

      // Player 2 takes the match, then DONE ignores everything
      do_reset();
      start_match();
      b1 = n_p1; b2 = n_p2;
      for (int r = 0; r < WL; r++) play_round(A_P2, r, d1, d2);
      check("p2 match pulses", n_p2 - b2, WL);
      check("p2 match p1 pulses", n_p1 - b1, 0);
      check("p2 match_over", match_over, 1);
      b1 = n_p1; b2 = n_p2; g = 0;
      for (int k = 0; k < 40; k++) begin
         start  = (k % 4) < 2;
         btn_p1 = (k % 10) < 5;
         btn_p2 = (k % 8) < 4;
         tick();
         if (go_led || round_active) g++;
      end
      start = 1'b0; btn_p1 = 1'b0; btn_p2 = 1'b0;
      check("done no pulses", (n_p1 - b1) + (n_p2 - b2), 0);
      check("done no round", g, 0);
      check("done holds match_over", match_over, 1);

      // Press during ARMED
      do_reset();
      start_match();
      b1 = n_p1; b2 = n_p2; f0 = n_falta; g = 0;
      btn_p2 = 1'b1;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (go_led) g++;
      end
      btn_p2 = 1'b0;
`ifdef FALSE_START_PENALTY_EN
      check("penalty p1vic", n_p1 - b1, 1);
      check("penalty p2vic", n_p2 - b2, 0);
      check("penalty falta seen", (n_falta - f0) > 0 ? 1 : 0, 1);
`else
      check("armed press p1vic", n_p1 - b1, 0);
      check("armed press p2vic", n_p2 - b2, 0);
      check("armed press falta", n_falta - f0, 0);
      check("armed press still armed", round_active, 1);
`endif
      check("armed press no go", g, 0);

      // Reset while in GO with a winning edge in flight, after 7 p1 wins
      do_reset();
      start_match();
      for (int r = 0; r < WL - 1; r++) play_round(A_P1, 1, d1, d2);
      check("pre-reset match_over", match_over, 0);
      g = 0;
      while (!go_led && g < 200) begin tick(); g++; end
      check("go before reset", go_led, 1);
      btn_p1 = 1'b1;
      tick(); tick(); tick();
      b1 = n_p1;
      reset = 1'b1;
      #1;
      check("async reset go_led", go_led, 0);
      check("async reset round_active", round_active, 0);
      check("async reset p1vic", p1vic, 0);
      tick(); tick(); tick();
      check("reset drops pulse", n_p1 - b1, 0);
      reset = 1'b0; btn_p1 = 1'b0;
      g = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (round_active) g++;
      end
      check("idle after reset", g, 0);
      start_match();
      play_round(A_P1, 2, d1, d2);
      check("post-reset p1vic", d1, 1);
      check("win counters cleared", match_over, 0);

      check("p1vic and p2vic overlap", n_both, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
